// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master: the controller (samples IR fields/flags/memory ready, drives every mux select and enable).
// slave:  the datapath/memory side (drives IR fields/flags/memory ready, samples the controls).
interface mips_multicycle_controller_if #(
    parameter int OPW = 6
);
    // Datapath -> controller
    logic [OPW-1:0] op_code;     // instr[31:26]
    logic [OPW-1:0] funct;       // instr[5:0]
    logic           zero;        // ALU zero flag
    logic           mem_ready;   // memory completes the current access this cycle

    // Controller -> datapath
    logic           mem_req;
    logic           mem_write;
    logic           iord;
    logic           ir_write;
    logic           reg_dest;
    logic           mem_reg;
    logic           reg_write;
    logic           ALU_SRC_A;
    logic [1:0]     ALU_SRC_B;
    logic [2:0]     ALU_control;
    logic [1:0]     PCSRC;
    logic           pc_en;
    logic           illegal_op;

    modport master (
        input  op_code, funct, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, reg_dest, mem_reg, reg_write,
               ALU_SRC_A, ALU_SRC_B, ALU_control, PCSRC, pc_en, illegal_op
    );

    modport slave (
        output op_code, funct, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, reg_dest, mem_reg, reg_write,
               ALU_SRC_A, ALU_SRC_B, ALU_control, PCSRC, pc_en, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Moore FSM sequencing a shared-resource multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Latency: controls are combinational from the state register; lw 5, R/sw/addi 4, beq/j 3 cycles plus memory waits.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready is low; nothing advances past an unfinished access.
// Ports: clk, reset (sync, active-high), bus (master modport: IR fields, zero, mem handshake, all
//        datapath controls), state (debug), retired/stall_cycles (perf counters).
// Optional: define MIPS_MC_PERF_CNT_EN to build the retired/stall_cycles counters; otherwise both read 0.
module mips_multicycle_controller #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    mips_multicycle_controller_if.master    bus,
    output logic [STW-1:0]                  state,
    output logic [31:0]                     retired,
    output logic [31:0]                     stall_cycles
);

    localparam logic [STW-1:0] S_FETCH  = STW'(0);
    localparam logic [STW-1:0] S_DECODE = STW'(1);
    localparam logic [STW-1:0] S_MEMADR = STW'(2);
    localparam logic [STW-1:0] S_MEMRD  = STW'(3);
    localparam logic [STW-1:0] S_MEMWB  = STW'(4);
    localparam logic [STW-1:0] S_MEMWR  = STW'(5);
    localparam logic [STW-1:0] S_EXEC   = STW'(6);
    localparam logic [STW-1:0] S_ALUWB  = STW'(7);
    localparam logic [STW-1:0] S_BRANCH = STW'(8);
    localparam logic [STW-1:0] S_ADDIEX = STW'(9);
    localparam logic [STW-1:0] S_ADDIWB = STW'(10);
    localparam logic [STW-1:0] S_JUMP   = STW'(11);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    localparam logic [OPW-1:0] FN_ADD   = OPW'(6'b100000);
    localparam logic [OPW-1:0] FN_SUB   = OPW'(6'b100010);
    localparam logic [OPW-1:0] FN_AND   = OPW'(6'b100100);
    localparam logic [OPW-1:0] FN_OR    = OPW'(6'b100101);
    localparam logic [OPW-1:0] FN_SLT   = OPW'(6'b101010);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [STW-1:0] state_q;
    logic [STW-1:0] state_d;

    assign state = state_q;

    // Next state and all datapath controls; every control defaults to 0.
    always_comb begin
        state_d         = state_q;
        bus.mem_req     = 1'b0;
        bus.mem_write   = 1'b0;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_dest    = 1'b0;
        bus.mem_reg     = 1'b0;
        bus.reg_write   = 1'b0;
        bus.ALU_SRC_A   = 1'b0;
        bus.ALU_SRC_B   = 2'b00;
        bus.ALU_control = 3'b000;
        bus.PCSRC       = 2'b00;
        bus.pc_en       = 1'b0;
        bus.illegal_op  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 computed while the instruction is fetched; IR and PC
                // only load on the cycle the memory actually returns data.
                bus.mem_req     = 1'b1;
                bus.ALU_SRC_B   = 2'b01;
                bus.ALU_control = ALU_ADD;
                bus.ir_write    = bus.mem_ready;
                bus.pc_en       = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                bus.ALU_SRC_B   = 2'b11;
                bus.ALU_control = ALU_ADD;
                case (bus.op_code)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d        = S_FETCH;
                        bus.illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALU_SRC_A   = 1'b1;
                bus.ALU_SRC_B   = 2'b10;
                bus.ALU_control = ALU_ADD;
                state_d = (bus.op_code == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                bus.reg_write = 1'b1;
                bus.mem_reg   = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                bus.ALU_SRC_A = 1'b1;
                // Unknown funct still completes as an add so the pipeline of
                // states stays uniform; illegal_op flags it to the system.
                case (bus.funct)
                    FN_ADD:  bus.ALU_control = ALU_ADD;
                    FN_SUB:  bus.ALU_control = ALU_SUB;
                    FN_AND:  bus.ALU_control = ALU_AND;
                    FN_OR:   bus.ALU_control = ALU_OR;
                    FN_SLT:  bus.ALU_control = ALU_SLT;
                    default: begin
                        bus.ALU_control = ALU_ADD;
                        bus.illegal_op  = 1'b1;
                    end
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dest  = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALU_SRC_A   = 1'b1;
                bus.ALU_control = ALU_SUB;
                bus.PCSRC       = 2'b01;
                bus.pc_en       = bus.zero;
                state_d         = S_FETCH;
            end
            S_ADDIEX: begin
                bus.ALU_SRC_A   = 1'b1;
                bus.ALU_SRC_B   = 2'b10;
                bus.ALU_control = ALU_ADD;
                state_d         = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSRC = 2'b10;
                bus.pc_en = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                // Unused encodings recover to FETCH.
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MIPS_MC_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] retired_d;
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic        retire;

    // An instruction retires on the edge that leaves its last state for
    // FETCH; the illegal-opcode exit from DECODE is deliberately excluded.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
            S_MEMWR:                                      retire = bus.mem_ready;
            default:                                      retire = 1'b0;
        endcase
        retired_d      = retired_q + 32'(retire);
        stall_cycles_d = stall_cycles_q + 32'(bus.mem_req & ~bus.mem_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            retired_q      <= retired_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign retired      = retired_q;
    assign stall_cycles = stall_cycles_q;
`else
    assign retired      = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: directed per-cycle vector table, reset corner
// cases, then randomized instruction streams checked against per-instruction totals.
module tb_mips_multicycle_controller;

`ifdef MIPS_MC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [31:0] retired;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    mips_multicycle_controller_if #(.OPW(6)) bus ();

    mips_multicycle_controller #(.OPW(6), .STW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .state        (state),
        .retired      (retired),
        .stall_cycles (stall_cycles)
    );

    // Observed control word, in the same field order as pk().
    logic [16:0] obs;
    assign obs = {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.reg_dest,
                  bus.mem_reg, bus.reg_write, bus.ALU_SRC_A, bus.ALU_SRC_B,
                  bus.ALU_control, bus.PCSRC, bus.pc_en, bus.illegal_op};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] pk(input logic mreq, input logic mwr, input logic iord,
                                       input logic irw, input logic rdst, input logic mreg,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [1:0] pcs,
                                       input logic pce, input logic ill);
        return {mreq, mwr, iord, irw, rdst, mreg, rw, sa, sb, alu, pcs, pce, ill};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] exp;
        logic        cnt_chk;
        int          ret;
        int          stl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] op, input logic [5:0] funct, input logic z,
                       input logic r, input logic [3:0] st, input logic [16:0] e);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = z; v.rdy = r; v.st = st; v.exp = e;
        v.cnt_chk = 1'b0; v.ret = 0; v.stl = 0;
        tbl.push_back(v);
    endtask

    task automatic add_cnt(input logic [5:0] op, input logic [5:0] funct, input logic [16:0] e,
                           input int ret, input int stl);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = 1'b0; v.rdy = 1'b1; v.st = 4'd0; v.exp = e;
        v.cnt_chk = 1'b1; v.ret = ret; v.stl = stl;
        tbl.push_back(v);
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_ADDI || op == OP_J;
    endfunction

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b101010;
    endfunction

    initial begin
        logic [16:0] f_rdy, f_wait, dec, dec_ill, memadr, memrd, memwb, memwr;
        logic [16:0] aluwb, br1, br0, addiwb, jmp;
        logic [5:0]  fns [4];
        logic [2:0]  alus[4];
        int exp_ret, exp_stl;

        f_rdy   = pk(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0);
        f_wait  = pk(1,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);
        dec     = pk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
        dec_ill = pk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
        memadr  = pk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        memrd   = pk(1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
        memwb   = pk(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0);
        memwr   = pk(1,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
        aluwb   = pk(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,0);
        br1     = pk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0);
        br0     = pk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0);
        addiwb  = pk(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0);
        jmp     = pk(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0);

        // lw with 2 fetch waits and 3 read waits: 10 cycles
        add(OP_LW, 6'd0, 0, 0, 4'd0, f_wait);
        add(OP_LW, 6'd0, 0, 0, 4'd0, f_wait);
        add(OP_LW, 6'd0, 0, 1, 4'd0, f_rdy);
        add(OP_LW, 6'd0, 0, 1, 4'd1, dec);
        add(OP_LW, 6'd0, 0, 1, 4'd2, memadr);
        for (int i = 0; i < 3; i++) add(OP_LW, 6'd0, 0, 0, 4'd3, memrd);
        add(OP_LW, 6'd0, 0, 1, 4'd3, memrd);
        add(OP_LW, 6'd0, 0, 1, 4'd4, memwb);
        // R-type add; its FETCH also checks counters after the lw
        add_cnt(OP_R, 6'b100000, f_rdy, 1, 5);
        add(OP_R, 6'b100000, 0, 1, 4'd1, dec);
        add(OP_R, 6'b100000, 0, 1, 4'd6, pk(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0));
        add(OP_R, 6'b100000, 0, 1, 4'd7, aluwb);
        // remaining R-type functions
        fns[0] = 6'b100010; alus[0] = 3'b110;
        fns[1] = 6'b100100; alus[1] = 3'b000;
        fns[2] = 6'b100101; alus[2] = 3'b001;
        fns[3] = 6'b101010; alus[3] = 3'b111;
        for (int i = 0; i < 4; i++) begin
            add(OP_R, fns[i], 0, 1, 4'd0, f_rdy);
            add(OP_R, fns[i], 0, 1, 4'd1, dec);
            add(OP_R, fns[i], 0, 1, 4'd6, pk(0,0,0,0,0,0,0,1,2'b00,alus[i],2'b00,0,0));
            add(OP_R, fns[i], 0, 1, 4'd7, aluwb);
        end
        // beq taken, then not taken
        add(OP_BEQ, 6'd0, 1, 1, 4'd0, f_rdy);
        add(OP_BEQ, 6'd0, 1, 1, 4'd1, dec);
        add(OP_BEQ, 6'd0, 1, 1, 4'd8, br1);
        add(OP_BEQ, 6'd0, 0, 1, 4'd0, f_rdy);
        add(OP_BEQ, 6'd0, 0, 1, 4'd1, dec);
        add(OP_BEQ, 6'd0, 0, 1, 4'd8, br0);
        // addi
        add(OP_ADDI, 6'd0, 0, 1, 4'd0, f_rdy);
        add(OP_ADDI, 6'd0, 0, 1, 4'd1, dec);
        add(OP_ADDI, 6'd0, 0, 1, 4'd9, memadr);
        add(OP_ADDI, 6'd0, 0, 1, 4'd10, addiwb);
        // sw then j: 7 cycles
        add(OP_SW, 6'd0, 0, 1, 4'd0, f_rdy);
        add(OP_SW, 6'd0, 0, 1, 4'd1, dec);
        add(OP_SW, 6'd0, 0, 1, 4'd2, memadr);
        add(OP_SW, 6'd0, 0, 1, 4'd5, memwr);
        add(OP_J, 6'd0, 0, 1, 4'd0, f_rdy);
        add(OP_J, 6'd0, 0, 1, 4'd1, dec);
        add(OP_J, 6'd0, 0, 1, 4'd11, jmp);
        // illegal opcode, then illegal funct
        add(6'b111111, 6'd0, 0, 1, 4'd0, f_rdy);
        add(6'b111111, 6'd0, 0, 1, 4'd1, dec_ill);
        add(OP_R, 6'b000111, 0, 1, 4'd0, f_rdy);
        add(OP_R, 6'b000111, 0, 1, 4'd1, dec);
        add(OP_R, 6'b000111, 0, 1, 4'd6, pk(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,1));
        add(OP_R, 6'b000111, 0, 1, 4'd7, aluwb);
        // lw, R x5, beq x2, addi, sw, j, bad-funct R retire; bad opcode does not
        add_cnt(OP_R, 6'b100000, f_rdy, 12, 5);

        // ---------------- reset ----------------
        reset = 1'b1;
        bus.op_code = OP_R; bus.funct = 6'b100000; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset mem_req", 32'(bus.mem_req), 32'd1);
        check("reset ctl word", 32'(obs), 32'(f_rdy));
        check("reset retired", retired, 32'd0);
        check("reset stall", stall_cycles, 32'd0);
        reset = 1'b0;

        // ---------------- vector table ----------------
        foreach (tbl[i]) begin
            bus.op_code   = tbl[i].op;
            bus.funct     = tbl[i].funct;
            bus.zero      = tbl[i].zero;
            bus.mem_ready = tbl[i].rdy;
            #1;
            check($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("vec%0d ctl", i), 32'(obs), 32'(tbl[i].exp));
            if (tbl[i].cnt_chk) begin
                check($sformatf("vec%0d retired", i), retired, PERF ? 32'(tbl[i].ret) : 32'd0);
                check($sformatf("vec%0d stall", i), stall_cycles, PERF ? 32'(tbl[i].stl) : 32'd0);
            end
            @(negedge clk);
        end

        // ---------------- reset during a stalled store ----------------
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.op_code = OP_SW; bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("sw stall state", 32'(state), 32'd5);
        check("sw stall mem_write", 32'(bus.mem_write), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mid-store reset state", 32'(state), 32'd0);
        check("mid-store reset mem_write", 32'(bus.mem_write), 32'd0);
        check("mid-store reset mem_req", 32'(bus.mem_req), 32'd1);
        check("mid-store reset retired", retired, 32'd0);
        check("mid-store reset stall", stall_cycles, 32'd0);
        reset = 1'b0;

        // ---------------- randomized instruction stream ----------------
        // Model: each instruction has a fixed base length and known points where
        // memory waits add cycles; checked as per-instruction totals.
        exp_ret = 0;
        exp_stl = 0;
        for (int n = 0; n < 300; n++) begin
            int kind, wf, wm, len, base, c;
            bit is_mem, z;
            int c_req, c_wr, c_irw, c_rw, c_pce, c_ill;
            logic [5:0] op, fn;
            kind = $urandom_range(7, 0);
            wf = $urandom_range(3, 0);
            wm = $urandom_range(3, 0);
            z  = 1'($urandom_range(1, 0));
            fn = 6'($urandom);
            case (kind)
                0: begin op = OP_LW;   base = 5; end
                1: begin op = OP_SW;   base = 4; end
                2: begin op = OP_R;    base = 4; fn = fns[$urandom_range(3, 0)]; end
                3: begin op = OP_R;    base = 4; while (legal_fn(fn)) fn = 6'($urandom); end
                4: begin op = OP_BEQ;  base = 3; end
                5: begin op = OP_ADDI; base = 4; end
                6: begin op = OP_J;    base = 3; end
                default: begin
                    op = 6'($urandom); base = 2;
                    while (legal_op(op)) op = 6'($urandom);
                end
            endcase
            is_mem = (kind == 0 || kind == 1);
            len = base + wf + (is_mem ? wm : 0);
            c_req = 0; c_wr = 0; c_irw = 0; c_rw = 0; c_pce = 0; c_ill = 0;
            bus.op_code = op; bus.funct = fn; bus.zero = z;
            for (c = 0; c < len; c++) begin
                if (c <= wf)
                    bus.mem_ready = (c == wf);
                else if (is_mem && c >= wf + 3)
                    bus.mem_ready = (c == wf + 3 + wm);
                else
                    bus.mem_ready = 1'($urandom_range(1, 0));
                #1;
                if (c == 0) check("rnd start in FETCH", 32'(state), 32'd0);
                check("rnd reg_write with mem_write", 32'(bus.reg_write & bus.mem_write), 32'd0);
                check("rnd mem_write outside MEMWR", 32'(bus.mem_write && state != 4'd5), 32'd0);
                c_req += int'(bus.mem_req);
                c_wr  += int'(bus.mem_write);
                c_irw += int'(bus.ir_write);
                c_rw  += int'(bus.reg_write);
                c_pce += int'(bus.pc_en);
                c_ill += int'(bus.illegal_op);
                @(negedge clk);
            end
            check("rnd mem_req cycles", 32'(c_req), 32'(wf + 1 + (is_mem ? wm + 1 : 0)));
            check("rnd mem_write cycles", 32'(c_wr), 32'(kind == 1 ? wm + 1 : 0));
            check("rnd ir_write pulses", 32'(c_irw), 32'd1);
            check("rnd reg_write cycles", 32'(c_rw),
                  32'((kind == 0 || kind == 2 || kind == 3 || kind == 5) ? 1 : 0));
            check("rnd pc_en cycles", 32'(c_pce),
                  32'(1 + (kind == 6 ? 1 : 0) + ((kind == 4 && z) ? 1 : 0)));
            check("rnd illegal_op pulses", 32'(c_ill), 32'((kind == 3 || kind == 7) ? 1 : 0));
            if (kind != 7) exp_ret++;
            exp_stl += wf + (is_mem ? wm : 0);
        end
        #1;
        check("rnd end state", 32'(state), 32'd0);
        check("rnd retired", retired, PERF ? 32'(exp_ret) : 32'd0);
        check("rnd stall", stall_cycles, PERF ? 32'(exp_stl) : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
